pipeline_ctrl: RTL and testbench

Hazard and stall sequencer for the five-stage pipeline. It drives enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It inserts load-use bubbles, freezes the pipeline on instruction or data cache misses, and remembers branch/jump flushes raised while the pipeline is frozen. It also holds the processor halted after HALT retires, and keeps saturating stall counters for performance analysis.

---
 rtl/pipeline_ctrl.sv | 102 ++++++++++
 tb/tb_pipeline_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the five-stage pipeline: load-use bubbles,
// cache-miss freezes, deferred branch flushes, sticky halt and stall counters.
module pipeline_ctrl #(
  parameter int unsigned REGW = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic            idex_dREN,
  input  logic [REGW-1:0] idex_wsel,
  input  logic            exmem_dREN,
  input  logic            exmem_dWEN,
  input  logic            branch_taken,
  input  logic            halt_in,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            halt,
  output logic [CNTW-1:0] dstall_cnt,
  output logic [CNTW-1:0] luse_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_flush_pend;
  logic [CNTW-1:0] r_dstall_cnt;
  logic [CNTW-1:0] r_luse_cnt;

  logic w_mem_pend;
  logic w_load_use;
  logic w_halted;
  logic w_stall_all;
  logic w_flush_now;

  // Hazard detection terms
  assign w_mem_pend  = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign w_load_use  = idex_dREN & (idex_wsel != '0) &
                       ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));
  assign w_halted    = (r_state == HALTED);
  assign w_stall_all = ~ihit | w_mem_pend | w_halted;
  assign w_flush_now = (branch_taken | r_flush_pend) & ~w_stall_all;

  // A pending flush overrides the load-use bubble so the redirect is fetched
  assign exmem_en   = ~w_stall_all;
  assign memwb_en   = ~w_stall_all;
  assign idex_en    = ~w_stall_all;
  assign pc_en      = ~w_stall_all & (~w_load_use | w_flush_now);
  assign ifid_en    = ~w_stall_all & (~w_load_use | w_flush_now);
  assign ifid_flush = w_flush_now;
  assign idex_flush = ~w_stall_all & (w_flush_now | w_load_use);
  assign halt       = w_halted;
  assign dstall_cnt = r_dstall_cnt;
  assign luse_cnt   = r_luse_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= RUN;
      r_flush_pend <= 1'b0;
      r_dstall_cnt <= '0;
      r_luse_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (halt_in && !w_mem_pend)  r_state <= HALTED;
          else if (w_mem_pend)         r_state <= DWAIT;
        end
        DWAIT: begin
          if (halt_in && !w_mem_pend)  r_state <= HALTED;
          else if (dhit)               r_state <= RUN;
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= RUN;
      endcase

      // Remember a redirect raised while frozen until the pipeline can take it
      if (w_flush_now)
        r_flush_pend <= 1'b0;
      else if (branch_taken && w_stall_all)
        r_flush_pend <= 1'b1;

      if (w_mem_pend && !w_halted && (r_dstall_cnt != '1))
        r_dstall_cnt <= r_dstall_cnt + CNTW'(1);

      if (w_load_use && !w_flush_now && !w_stall_all && (r_luse_cnt != '1))
        r_luse_cnt <= r_luse_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares the DUT's controls and counters.
module tb_pipeline_ctrl;

  localparam int unsigned REGW = 5;
  localparam int unsigned CNTW = 16;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt}
  localparam logic [7:0] RUNV   = 8'b11111_00_0;
  localparam logic [7:0] FREEZE = 8'b00000_00_0;
  localparam logic [7:0] LUSE   = 8'b00111_01_0;
  localparam logic [7:0] FLUSH  = 8'b11111_11_0;
  localparam logic [7:0] HALTV  = 8'b00000_00_1;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic [15:0] dst;
    logic [15:0] lu;
  } exp_t;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            ihit, dhit;
  logic [REGW-1:0] ifid_rs, ifid_rt, idex_wsel;
  logic            idex_dREN, exmem_dREN, exmem_dWEN, branch_taken, halt_in;
  logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, halt;
  logic [CNTW-1:0] dstall_cnt, luse_cnt;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  pipeline_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_dREN(idex_dREN),
    .idex_wsel(idex_wsel), .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .branch_taken(branch_taken), .halt_in(halt_in),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halt(halt), .dstall_cnt(dstall_cnt), .luse_cnt(luse_cnt)
  );

  always #5 CLK = ~CLK;

  // Monitor: compare the DUT against the oldest expectation each falling edge
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = q.pop_front();
      got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt};
      total++;
      if (got !== e.ctl || dstall_cnt !== e.dst || luse_cnt !== e.lu) begin
        bad++;
        $display("FAIL %s: got ctl=%b dstall=%0d luse=%0d, want ctl=%b dstall=%0d luse=%0d",
                 e.name, got, dstall_cnt, luse_cnt, e.ctl, e.dst, e.lu);
      end
    end
  end

  task automatic drive(input logic ih, input logic dh, input logic [4:0] rs,
                       input logic [4:0] rt, input logic idr, input logic [4:0] ws,
                       input logic exr, input logic exw, input logic br, input logic hin);
    ihit = ih; dhit = dh; ifid_rs = rs; ifid_rt = rt; idex_dREN = idr;
    idex_wsel = ws; exmem_dREN = exr; exmem_dWEN = exw; branch_taken = br;
    halt_in = hin;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Push the expectation for the current cycle, then advance one clock
  task automatic step(input string nm, input logic [7:0] ctl,
                      input logic [15:0] ds, input logic [15:0] lu);
    exp_t e;
    e.name = nm; e.ctl = ctl; e.dst = ds; e.lu = lu;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    @(posedge CLK); #1;
    step("reset", RUNV, 0, 0);
    nRST = 1'b1;
    idle();                               step("idle", RUNV, 0, 0);

    drive(1, 0, 5, 0, 1, 5, 0, 0, 0, 0);  step("luse_rs", LUSE, 0, 0);
    idle();                               step("luse_resume", RUNV, 0, 1);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);  step("luse_r0", RUNV, 0, 1);
    drive(1, 0, 3, 7, 1, 7, 0, 0, 0, 0);  step("luse_rt", LUSE, 0, 1);
    idle();                               step("luse_rt_after", RUNV, 0, 2);
    drive(0, 0, 5, 0, 1, 5, 0, 0, 0, 0);  step("luse_imiss", FREEZE, 0, 2);
    drive(1, 0, 5, 0, 1, 5, 0, 0, 0, 0);  step("luse_ihit", LUSE, 0, 2);
    idle();                               step("luse_done", RUNV, 0, 3);

    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);  step("dmiss0", FREEZE, 0, 3);
                                          step("dmiss1", FREEZE, 1, 3);
                                          step("dmiss2", FREEZE, 2, 3);
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);  step("dmiss_hit", RUNV, 3, 3);
    idle();                               step("dmiss_after", RUNV, 3, 3);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);  step("dwen_miss", FREEZE, 3, 3);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);  step("dwen_hit", RUNV, 4, 3);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step("br_frz0", FREEZE, 4, 3);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step("br_frz1", FREEZE, 4, 3);
                                          step("br_frz2", FREEZE, 4, 3);
    idle();                               step("br_release", FLUSH, 4, 3);
                                          step("br_after", RUNV, 4, 3);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);  step("br_dmiss", FREEZE, 4, 3);
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);  step("br_dhit", FLUSH, 5, 3);
    idle();                               step("br_dmiss_after", RUNV, 5, 3);

    drive(1, 0, 5, 0, 1, 5, 0, 0, 1, 0);  step("br_luse", FLUSH, 5, 3);
    idle();                               step("br_luse_after", RUNV, 5, 3);

    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);  step("halt_mempend", FREEZE, 5, 3);
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 1);  step("halt_sample", RUNV, 6, 3);
    drive(1, 0, 5, 0, 1, 5, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) step("halted_hold", HALTV, 6, 3);

    idle();
    nRST = 1'b0;                          step("reset_halted", RUNV, 0, 0);
    nRST = 1'b1;                          step("post_reset", RUNV, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 65540; i++)
      step("sat", FREEZE, (i > 65535) ? 16'hFFFF : 16'(i), 0);
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);  step("sat_hold", RUNV, 16'hFFFF, 0);

    @(negedge CLK); #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
